// File: rtl/exception_ctrl_pkg.sv
// ============================================================================
// Module : exception_ctrl_pkg
// Brief  : Shared defines for the exception controller. These are exception
//          codes, the handler vector, CP0 register addresses and FSM states.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exception_ctrl_pkg;

  localparam logic        c_RESET_ENABLE   = 1'b1;

  localparam logic [31:0] c_EXC_NONE       = 32'h0000_0000;
  localparam logic [31:0] c_EXC_INTERRUPT  = 32'h0000_0001;
  localparam logic [31:0] c_EXC_SYSCALL    = 32'h0000_0008;
  localparam logic [31:0] c_EXC_INVALID    = 32'h0000_000a;
  localparam logic [31:0] c_EXC_TRAP       = 32'h0000_000d;
  localparam logic [31:0] c_EXC_OVERFLOW   = 32'h0000_000c;
  localparam logic [31:0] c_EXC_ERET       = 32'h0000_000e;

  localparam logic [31:0] c_HANDLER_VECTOR = 32'h0000_0020;

  localparam logic [4:0]  c_CP0_STATUS     = 5'd12;
  localparam logic [4:0]  c_CP0_CAUSE      = 5'd13;
  localparam logic [4:0]  c_CP0_EPC        = 5'd14;

  // Bit positions inside exception_flags_input
  localparam int c_FLAG_SYSCALL  = 0;
  localparam int c_FLAG_INVALID  = 1;
  localparam int c_FLAG_TRAP     = 2;
  localparam int c_FLAG_OVERFLOW = 3;
  localparam int c_FLAG_ERET     = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/exception_ctrl_bypass.sv
// ============================================================================
// Module : exception_ctrl_bypass
// Brief  : Forwards a pending wb-stage mtc0 write into the CP0 values seen by
//          the exception logic.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exception_ctrl_bypass
  import exception_ctrl_pkg::*;
(
  input  logic [31:0] cp0_status_input,
  input  logic [31:0] cp0_cause_input,
  input  logic [31:0] cp0_epc_input,
  input  logic        wb_cp0_write_enable_input,
  input  logic [4:0]  wb_cp0_write_address_input,
  input  logic [31:0] wb_cp0_data_input,
  output logic [31:0] status_output,
  output logic [31:0] cause_output,
  output logic [31:0] epc_output
);

  always_comb begin
    status_output = cp0_status_input;
    cause_output  = cp0_cause_input;
    epc_output    = cp0_epc_input;
    if (wb_cp0_write_enable_input) begin
      case (wb_cp0_write_address_input)
        c_CP0_STATUS: status_output = wb_cp0_data_input;
        // Only the software-interrupt bits of Cause are writable
        c_CP0_CAUSE:  cause_output[9:8] = wb_cp0_data_input[9:8];
        c_CP0_EPC:    epc_output = wb_cp0_data_input;
        default:      ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/exception_ctrl.sv
// ============================================================================
// Module : exception_ctrl
// Brief  : Mem-stage exception prioritiser and one-cycle flush sequencer.
//          Define EXCEPTION_CTRL_WB_BYPASS_EN to forward wb-stage CP0 writes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exception_ctrl
  import exception_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  exception_flags_input,
  input  logic [31:0] current_instruction_address_input,
  input  logic        is_in_delay_slot_input,
  input  logic        instruction_valid_input,
  input  logic        stall_input,
  input  logic [31:0] cp0_status_input,
  input  logic [31:0] cp0_cause_input,
  input  logic [31:0] cp0_epc_input,
  input  logic        wb_cp0_write_enable_input,
  input  logic [4:0]  wb_cp0_write_address_input,
  input  logic [31:0] wb_cp0_data_input,
  output logic [31:0] exception_type_output,
  output logic [31:0] current_instruction_address_output,
  output logic        is_in_delay_slot_output,
  output logic        flush_output,
  output logic [31:0] new_pc_output
);

  state_t      r_state;
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic [31:0] w_epc;
  logic        w_irq;
  logic        w_commit;

`ifdef EXCEPTION_CTRL_WB_BYPASS_EN
  exception_ctrl_bypass u_bypass (
    .cp0_status_input           (cp0_status_input),
    .cp0_cause_input            (cp0_cause_input),
    .cp0_epc_input              (cp0_epc_input),
    .wb_cp0_write_enable_input  (wb_cp0_write_enable_input),
    .wb_cp0_write_address_input (wb_cp0_write_address_input),
    .wb_cp0_data_input          (wb_cp0_data_input),
    .status_output              (w_status),
    .cause_output               (w_cause),
    .epc_output                 (w_epc)
  );
`else
  assign w_status = cp0_status_input;
  assign w_cause  = cp0_cause_input;
  assign w_epc    = cp0_epc_input;

  logic w_unused_wb;
  assign w_unused_wb = ^{wb_cp0_write_enable_input, wb_cp0_write_address_input,
                         wb_cp0_data_input};
`endif

  logic w_unused_cp0;
  assign w_unused_cp0 = ^{w_status[31:16], w_status[7:2], w_cause[31:16], w_cause[7:0]};

  assign w_irq = (|(w_status[15:8] & w_cause[15:8])) && !w_status[1] && w_status[0];

  // Reset gating keeps the code quiet even if the state register is stale
  assign w_commit = (reset != c_RESET_ENABLE) && (r_state == ST_IDLE) &&
                    instruction_valid_input && !stall_input;

  always_comb begin
    exception_type_output = c_EXC_NONE;
    if (w_commit) begin
      if (w_irq)                                      exception_type_output = c_EXC_INTERRUPT;
      else if (exception_flags_input[c_FLAG_SYSCALL])  exception_type_output = c_EXC_SYSCALL;
      else if (exception_flags_input[c_FLAG_INVALID])  exception_type_output = c_EXC_INVALID;
      else if (exception_flags_input[c_FLAG_TRAP])     exception_type_output = c_EXC_TRAP;
      else if (exception_flags_input[c_FLAG_OVERFLOW]) exception_type_output = c_EXC_OVERFLOW;
      else if (exception_flags_input[c_FLAG_ERET])     exception_type_output = c_EXC_ERET;
    end
  end

  assign current_instruction_address_output = current_instruction_address_input;
  assign is_in_delay_slot_output            = is_in_delay_slot_input;

  always_ff @(posedge clock) begin
    if (reset == c_RESET_ENABLE) begin
      r_state       <= ST_IDLE;
      flush_output  <= 1'b0;
      new_pc_output <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          flush_output <= 1'b0;
          if (exception_type_output != c_EXC_NONE) begin
            r_state       <= ST_FLUSH;
            flush_output  <= 1'b1;
            new_pc_output <= (exception_type_output == c_EXC_ERET) ? w_epc : c_HANDLER_VECTOR;
          end
        end
        ST_FLUSH: begin
          r_state      <= ST_IDLE;
          flush_output <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          flush_output <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exception_ctrl.sv
// ============================================================================
// Module : tb_exception_ctrl
// Brief  : Directed self-checking bench for exception_ctrl; redirect targets
//          are queued at commit and checked whenever a flush pulse appears.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exception_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  flags;
  logic [31:0] pc_in;
  logic        ds_in;
  logic        valid;
  logic        stall;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] exc_type;
  logic [31:0] pc_out;
  logic        ds_out;
  logic        flush;
  logic [31:0] new_pc;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  logic [31:0] exp_pc_q[$];

  localparam logic [4:0] c_SYS  = 5'b00001;
  localparam logic [4:0] c_INV  = 5'b00010;
  localparam logic [4:0] c_TRP  = 5'b00100;
  localparam logic [4:0] c_OVF  = 5'b01000;
  localparam logic [4:0] c_ERET = 5'b10000;

  always #5 clock = ~clock;

  exception_ctrl dut (
    .clock                              (clock),
    .reset                              (reset),
    .exception_flags_input              (flags),
    .current_instruction_address_input  (pc_in),
    .is_in_delay_slot_input             (ds_in),
    .instruction_valid_input            (valid),
    .stall_input                        (stall),
    .cp0_status_input                   (status),
    .cp0_cause_input                    (cause),
    .cp0_epc_input                      (epc),
    .wb_cp0_write_enable_input          (wb_we),
    .wb_cp0_write_address_input         (wb_addr),
    .wb_cp0_data_input                  (wb_data),
    .exception_type_output              (exc_type),
    .current_instruction_address_output (pc_out),
    .is_in_delay_slot_output            (ds_out),
    .flush_output                       (flush),
    .new_pc_output                      (new_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    flags = 5'b0; valid = 1'b0; stall = 1'b0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    status = 32'h0; cause = 32'h0; epc = 32'h0;
  endtask

  // Every flush pulse consumes the redirect target queued at its commit
  always @(negedge clock) begin
    if (flush === 1'b1) begin
      pulses++;
      if (exp_pc_q.size() == 0) chk("unexpected_flush", 32'h1, 32'h0);
      else                      chk("flush_new_pc", new_pc, exp_pc_q.pop_front());
    end
  end

  initial begin
    reset = 1'b1; pc_in = 32'h0; ds_in = 1'b0;
    idle_inputs();
    flags = c_SYS; valid = 1'b1;
    cyc(); cyc();
    #3;
    chk("reset_exc_type", exc_type, 32'h0);
    chk("reset_flush", {31'h0, flush}, 32'h0);
    chk("reset_new_pc", new_pc, 32'h0);
    cyc();
    reset = 1'b0; idle_inputs();
    cyc();

    // Syscall commit and one-cycle flush
    flags = c_SYS; valid = 1'b1; pc_in = 32'h0000_0100; ds_in = 1'b1;
    #3;
    chk("sys_code", exc_type, 32'h8);
    chk("pc_pass", pc_out, 32'h100);
    chk("ds_pass", {31'h0, ds_out}, 32'h1);
    exp_pc_q.push_back(32'h20);
    cyc(); idle_inputs(); ds_in = 1'b0;
    chk("sys_flush", {31'h0, flush}, 32'h1);
    chk("sys_new_pc", new_pc, 32'h20);
    cyc();
    chk("sys_flush_end", {31'h0, flush}, 32'h0);

    // Priority walk, then interrupt wins over invalid+overflow
    valid = 1'b1;
    flags = c_TRP | c_OVF | c_ERET; #1; chk("prio_trap", exc_type, 32'hd);
    flags = c_OVF | c_ERET;         #1; chk("prio_ovf", exc_type, 32'hc);
    flags = c_ERET;                 #1; chk("prio_eret", exc_type, 32'he);
    flags = c_INV | c_OVF; status = 32'h0000_0403; cause = 32'h0000_0400;
    #1; chk("exl_blocks_irq", exc_type, 32'ha);
    status = 32'h0000_0400; #1; chk("ie_off_blocks_irq", exc_type, 32'ha);
    status = 32'h0000_0401; #1; chk("irq_wins", exc_type, 32'h1);
    exp_pc_q.push_back(32'h20);
    cyc(); idle_inputs();
    chk("irq_flush", {31'h0, flush}, 32'h1);
    cyc();

    // Eret target with a same-cycle EPC write in wb
    flags = c_ERET; valid = 1'b1; epc = 32'h0000_0200;
    wb_we = 1'b1; wb_addr = 5'd14; wb_data = 32'h0000_0300;
    #3; chk("eret_code", exc_type, 32'he);
`ifdef EXCEPTION_CTRL_WB_BYPASS_EN
    exp_pc_q.push_back(32'h300);
`else
    exp_pc_q.push_back(32'h200);
`endif
    cyc(); idle_inputs();
    cyc();

    // Interrupt enabled only through wb writes to Status and Cause[9:8]
    valid = 1'b1; status = 32'h0; cause = 32'h0;
    wb_we = 1'b1; wb_addr = 5'd13; wb_data = 32'hffff_fdff;
    #1;
`ifdef EXCEPTION_CTRL_WB_BYPASS_EN
    chk("wb_cause_only", exc_type, 32'h0);
    status = 32'h0000_0101; #1; chk("wb_cause_irq", exc_type, 32'h1);
    exp_pc_q.push_back(32'h20);
`else
    chk("wb_cause_ignored", exc_type, 32'h0);
    status = 32'h0000_0101; #1; chk("wb_cause_raw", exc_type, 32'h0);
`endif
    cyc(); idle_inputs();
    cyc();

    // Stall holds off detection
    flags = c_SYS; valid = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("stall_code", exc_type, 32'h0);
      chk("stall_flush", {31'h0, flush}, 32'h0);
      cyc();
    end
    stall = 1'b0;
    #3; chk("unstall_code", exc_type, 32'h8);
    exp_pc_q.push_back(32'h20);
    cyc(); idle_inputs();
    chk("unstall_flush", {31'h0, flush}, 32'h1);
    cyc();

    // Syscall on two consecutive cycles gives one pulse
    pulses = 0;
    flags = c_SYS; valid = 1'b1;
    #3; exp_pc_q.push_back(32'h20);
    cyc();
    #3; chk("b2b_ignored", exc_type, 32'h0);
    cyc(); idle_inputs();
    cyc(); cyc();
    chk("b2b_pulses", pulses, 32'd1);

    // Reset during FLUSH aborts the pulse
    flags = c_SYS; valid = 1'b1;
    #3; exp_pc_q.push_back(32'h20);
    cyc(); idle_inputs();
    reset = 1'b1;
    cyc();
    chk("rst_flush", {31'h0, flush}, 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    reset = 1'b0;
    cyc(); cyc();

    chk("queue_drained", exp_pc_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
